// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: FSM state encoding, command codes, default widths.
package xbar_pkg;

  localparam int unsigned XBAR_ADDR_W = 32;
  localparam int unsigned XBAR_DATA_W = 32;
  localparam int unsigned XBAR_ID_W   = 2;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } state_t;

  // Width of a counter able to hold 0..t; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/slave_port_timer.sv
// Watchdog for the slave port: counts enabled cycles and flags the terminal one.
module slave_port_timer
  import xbar_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = clk ^ rst ^ clear ^ enable;
      assign expire        = 1'b0;
    end else begin : g_on
      localparam int unsigned     CW   = cnt_width(TIMEOUT_CYCLES);
      localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] count;

      // Count enabled cycles; hold at the terminal value so the counter cannot wrap.
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          count <= '0;
        end else if (enable && (count != LAST)) begin
          count <= count + CW'(1);
        end
      end

      assign expire = enable && (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/slave_port_ctrl.sv
// Slave-side crossbar port: latches a granted request, holds it to the slave
// until ack or watchdog timeout, then returns a single ack pulse to the crossbar.
module slave_port_ctrl
  import xbar_pkg::*;
#(
  parameter int unsigned ADDR_W         = XBAR_ADDR_W,
  parameter int unsigned DATA_W         = XBAR_DATA_W,
  parameter int unsigned ID_W           = XBAR_ID_W,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_from_crossbar,
  input  logic [ADDR_W-1:0] addr_from_crossbar,
  input  logic [DATA_W-1:0] wdata_from_crossbar,
  input  logic              cmd_from_crossbar,
  input  logic              connect_approved_from_crossbar,
  input  logic [ID_W-1:0]   master_id_from_crossbar,
  output logic              ack_to_crossbar,
  output logic [DATA_W-1:0] rdata_to_crossbar,
  output logic              err_to_crossbar,
  output logic [ID_W-1:0]   master_id_to_crossbar,
  output logic              busy_to_crossbar,
  output logic              req_to_slave,
  output logic [ADDR_W-1:0] addr_to_slave,
  output logic [DATA_W-1:0] wdata_to_slave,
  output logic              cmd_to_slave,
  input  logic              ack_from_slave,
  input  logic [DATA_W-1:0] rdata_from_slave
);

  state_t              state;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                lat_cmd;
  logic [ID_W-1:0]     lat_id;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;
  logic                expire;

  // Counter runs only in REQ and is held clear otherwise, so it restarts on every entry.
  slave_port_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != REQ),
    .enable (state == REQ),
    .expire (expire)
  );

  // Transaction FSM with request and response latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_cmd    <= CMD_READ;
      lat_id     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_from_crossbar && connect_approved_from_crossbar) begin
            lat_addr  <= addr_from_crossbar;
            lat_wdata <= wdata_from_crossbar;
            lat_cmd   <= cmd_from_crossbar;
            lat_id    <= master_id_from_crossbar;
            state     <= REQ;
          end
        end
        REQ: begin
          // A slave ack on the terminal watchdog cycle still completes cleanly.
          if (ack_from_slave) begin
            resp_rdata <= (lat_cmd == CMD_READ) ? rdata_from_slave : '0;
            resp_err   <= 1'b0;
            state      <= RESP;
          end else if (expire) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
            state      <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode state and latches only; everything outside its valid window reads 0.
  always_comb begin
    ack_to_crossbar       = (state == RESP);
    rdata_to_crossbar     = (state == RESP) ? resp_rdata : '0;
    err_to_crossbar       = (state == RESP) && resp_err;
    master_id_to_crossbar = (state == RESP) ? lat_id : '0;
    busy_to_crossbar      = (state != IDLE);
    req_to_slave          = (state == REQ);
    addr_to_slave         = (state == REQ) ? lat_addr : '0;
    wdata_to_slave        = ((state == REQ) && (lat_cmd == CMD_WRITE)) ? lat_wdata : '0;
    cmd_to_slave          = (state == REQ) && lat_cmd;
  end

endmodule

// File: tb/tb_slave_port_ctrl.sv
// Self-checking bench for slave_port_ctrl: transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_slave_port_ctrl;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_from_crossbar;
  logic [31:0] addr_from_crossbar;
  logic [31:0] wdata_from_crossbar;
  logic        cmd_from_crossbar;
  logic        connect_approved_from_crossbar;
  logic [1:0]  master_id_from_crossbar;
  logic        ack_to_crossbar;
  logic [31:0] rdata_to_crossbar;
  logic        err_to_crossbar;
  logic [1:0]  master_id_to_crossbar;
  logic        busy_to_crossbar;
  logic        req_to_slave;
  logic [31:0] addr_to_slave;
  logic [31:0] wdata_to_slave;
  logic        cmd_to_slave;
  logic        ack_from_slave;
  logic [31:0] rdata_from_slave;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_pulses = 0;
  bit check_en = 1'b0;

  slave_port_ctrl #(
    .ADDR_W(32), .DATA_W(32), .ID_W(2), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst),
    .req_from_crossbar(req_from_crossbar),
    .addr_from_crossbar(addr_from_crossbar),
    .wdata_from_crossbar(wdata_from_crossbar),
    .cmd_from_crossbar(cmd_from_crossbar),
    .connect_approved_from_crossbar(connect_approved_from_crossbar),
    .master_id_from_crossbar(master_id_from_crossbar),
    .ack_to_crossbar(ack_to_crossbar),
    .rdata_to_crossbar(rdata_to_crossbar),
    .err_to_crossbar(err_to_crossbar),
    .master_id_to_crossbar(master_id_to_crossbar),
    .busy_to_crossbar(busy_to_crossbar),
    .req_to_slave(req_to_slave),
    .addr_to_slave(addr_to_slave),
    .wdata_to_slave(wdata_to_slave),
    .cmd_to_slave(cmd_to_slave),
    .ack_from_slave(ack_from_slave),
    .rdata_from_slave(rdata_from_slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: one outstanding transaction, its age in cycles, and a pending response.
  bit          m_active, m_resp, m_cmd, m_err;
  int          m_age;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_id;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_resp = 0; m_age = 0; m_cmd = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_id = '0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_active) begin
      m_age++;
      if (ack_from_slave) begin
        m_rdata = m_cmd ? 32'h0 : rdata_from_slave;
        m_err = 0; m_resp = 1; m_active = 0;
      end else if (T > 0 && m_age == int'(T)) begin
        m_rdata = 32'h0; m_err = 1; m_resp = 1; m_active = 0;
      end
    end else if (req_from_crossbar && connect_approved_from_crossbar) begin
      m_active = 1; m_age = 0;
      m_addr = addr_from_crossbar; m_wdata = wdata_from_crossbar;
      m_cmd = cmd_from_crossbar; m_id = master_id_from_crossbar;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (ack_to_crossbar === 1'b1) ack_pulses++;
    if (check_en) begin
      chk("ack",   64'(ack_to_crossbar),       64'(m_resp));
      chk("rdata", 64'(rdata_to_crossbar),     64'(m_resp ? m_rdata : 32'h0));
      chk("err",   64'(err_to_crossbar),       64'(m_resp && m_err));
      chk("id",    64'(master_id_to_crossbar), 64'(m_resp ? m_id : 2'd0));
      chk("busy",  64'(busy_to_crossbar),      64'(m_active || m_resp));
      chk("sreq",  64'(req_to_slave),          64'(m_active));
      chk("saddr", 64'(addr_to_slave),         64'(m_active ? m_addr : 32'h0));
      chk("swdat", 64'(wdata_to_slave),        64'((m_active && m_cmd) ? m_wdata : 32'h0));
      chk("scmd",  64'(cmd_to_slave),          64'(m_active && m_cmd));
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive_req(input logic cmd, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] id);
    req_from_crossbar = 1'b1; connect_approved_from_crossbar = 1'b1;
    cmd_from_crossbar = cmd; addr_from_crossbar = a; wdata_from_crossbar = wd;
    master_id_from_crossbar = id;
  endtask

  task automatic drop_req();
    req_from_crossbar = 1'b0; connect_approved_from_crossbar = 1'b0;
    addr_from_crossbar = 32'hFFFF_FFFF; wdata_from_crossbar = 32'h5555_5555;
    cmd_from_crossbar = 1'b1; master_id_from_crossbar = 2'd3;
  endtask

  int p0;
  int req_cycles;
  bit seen;

  initial begin
    rst = 1'b1; ack_from_slave = 1'b0; rdata_from_slave = '0;
    req_from_crossbar = 0; connect_approved_from_crossbar = 0;
    addr_from_crossbar = '0; wdata_from_crossbar = '0; cmd_from_crossbar = 0;
    master_id_from_crossbar = '0;
    step(3);
    chk("rst_ack", 64'(ack_to_crossbar), 64'd0);
    chk("rst_busy", 64'(busy_to_crossbar), 64'd0);
    chk("rst_sreq", 64'(req_to_slave), 64'd0);
    rst = 1'b0;
    check_en = 1'b1;
    step(1);

    // 1: read, slave acks on the third cycle after req_to_slave rises
    p0 = ack_pulses;
    drive_req(1'b0, 32'h0000_0100, 32'h0, 2'd2);
    step(1);
    drop_req();
    chk("t1_sreq", 64'(req_to_slave), 64'd1);
    step(2);
    chk("t1_addr_hold", 64'(addr_to_slave), 64'h100);
    ack_from_slave = 1'b1; rdata_from_slave = 32'hDEADBEEF;
    step(1);
    ack_from_slave = 1'b0; rdata_from_slave = 32'h0BAD_0BAD;
    chk("t1_ack", 64'(ack_to_crossbar), 64'd1);
    chk("t1_rdata", 64'(rdata_to_crossbar), 64'hDEADBEEF);
    chk("t1_err", 64'(err_to_crossbar), 64'd0);
    chk("t1_id", 64'(master_id_to_crossbar), 64'd2);
    step(1);
    chk("t1_ack_end", 64'(ack_to_crossbar), 64'd0);
    chk("t1_pulses", 64'(ack_pulses - p0), 64'd1);

    // 2: write, slave acks on the first REQ cycle
    drive_req(1'b1, 32'h0000_0010, 32'hA5A5A5A5, 2'd1);
    step(1);
    drop_req();
    chk("t2_wdata_req", 64'(wdata_to_slave), 64'hA5A5A5A5);
    ack_from_slave = 1'b1; rdata_from_slave = 32'h1111_2222;
    step(1);
    ack_from_slave = 1'b0;
    chk("t2_ack", 64'(ack_to_crossbar), 64'd1);
    chk("t2_rdata", 64'(rdata_to_crossbar), 64'd0);
    chk("t2_wdata_resp", 64'(wdata_to_slave), 64'd0);
    step(1);

    // 3: watchdog, slave never acks
    drive_req(1'b0, 32'h0000_0200, 32'h0, 2'd3);
    step(1);
    drop_req();
    req_cycles = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (ack_to_crossbar === 1'b1) begin
        seen = 1;
        chk("t3_err", 64'(err_to_crossbar), 64'd1);
        chk("t3_rdata", 64'(rdata_to_crossbar), 64'd0);
      end else begin
        if (req_to_slave === 1'b1) req_cycles++;
        step(1);
      end
    end
    chk("t3_ack_seen", 64'(seen), 64'd1);
    chk("t3_req_cycles", 64'(req_cycles), 64'd8);
    step(1);

    // 4: slave ack on the terminal watchdog cycle
    drive_req(1'b0, 32'h0000_0300, 32'h0, 2'd0);
    step(1);
    drop_req();
    step(int'(T) - 1);
    chk("t4_still_req", 64'(req_to_slave), 64'd1);
    ack_from_slave = 1'b1; rdata_from_slave = 32'h1234_5678;
    step(1);
    ack_from_slave = 1'b0;
    chk("t4_ack", 64'(ack_to_crossbar), 64'd1);
    chk("t4_err", 64'(err_to_crossbar), 64'd0);
    chk("t4_rdata", 64'(rdata_to_crossbar), 64'h12345678);
    step(1);

    // 5: unapproved request, stray slave ack, request held through RESP
    req_from_crossbar = 1'b1; connect_approved_from_crossbar = 1'b0;
    step(3);
    chk("t5_noapp", 64'(req_to_slave), 64'd0);
    req_from_crossbar = 1'b0;
    p0 = ack_pulses;
    ack_from_slave = 1'b1; rdata_from_slave = 32'hCAFE_F00D;
    step(2);
    ack_from_slave = 1'b0;
    step(1);
    chk("t5_stray", 64'(ack_pulses - p0), 64'd0);
    drive_req(1'b0, 32'h0000_0400, 32'h0, 2'd1);
    step(1);
    ack_from_slave = 1'b1; rdata_from_slave = 32'h0000_00AA;
    step(1);
    ack_from_slave = 1'b0;
    chk("t5_resp_busy", 64'(busy_to_crossbar), 64'd1);
    step(1);
    chk("t5_idle_gap", 64'(req_to_slave), 64'd0);
    step(1);
    chk("t5_reaccept", 64'(req_to_slave), 64'd1);
    drop_req();
    ack_from_slave = 1'b1; rdata_from_slave = 32'h0000_00BB;
    step(1);
    ack_from_slave = 1'b0;
    chk("t5_ack2", 64'(rdata_to_crossbar), 64'hBB);
    step(1);

    // 6: reset mid-REQ, then a fresh transaction
    p0 = ack_pulses;
    drive_req(1'b1, 32'h0000_0500, 32'h7777_8888, 2'd2);
    step(1);
    drop_req();
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_sreq", 64'(req_to_slave), 64'd0);
    chk("t6_busy", 64'(busy_to_crossbar), 64'd0);
    chk("t6_addr", 64'(addr_to_slave), 64'd0);
    chk("t6_wdata", 64'(wdata_to_slave), 64'd0);
    step(int'(T) + 2);
    chk("t6_no_ack", 64'(ack_pulses - p0), 64'd0);
    drive_req(1'b0, 32'h0000_0600, 32'h0, 2'd3);
    step(1);
    drop_req();
    ack_from_slave = 1'b1; rdata_from_slave = 32'h600D_600D;
    step(1);
    ack_from_slave = 1'b0;
    chk("t6_ack", 64'(ack_to_crossbar), 64'd1);
    chk("t6_rdata", 64'(rdata_to_crossbar), 64'h600D600D);
    chk("t6_id", 64'(master_id_to_crossbar), 64'd3);
    step(2);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
